ppu_tile_engine: RTL and testbench

//  Renders one 320-pixel scanline of a 512x512 scrolling tile layer into a double-buffered line buffer.

---
 rtl/ppu_tile_engine.sv | 184 ++++++++++++++++++
 tb/tb_ppu_tile_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ppu_tile_engine.sv
// Scrolling tile-layer scanline renderer: fetches tile entries and 4bpp patterns,
// renders 41 tiles into the back half of a double-buffered line buffer.
module ppu_tile_engine #(
   parameter bit FG = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  next_row,
   output logic [10:0] tilram_addr,
   input  logic [63:0] tilram_rddata,
   output logic [11:0] patram_addr,
   input  logic [63:0] patram_rddata,
   input  logic [17:0] scroll,
   input  logic        enable,
   input  logic        prep,
   input  logic [8:0]  pixel_addr,
   output logic [7:0]  pixel_data,
   output logic        done
);

   localparam int unsigned LINE_W    = 320;
   localparam logic [5:0]  LAST_TILE = 6'd40;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic        front;
   logic [1:0]  buf_valid;
   logic [7:0]  lbuf [2][LINE_W];

   logic [8:0]  ly_r;
   logic [8:0]  sx_r;
   logic        en_r;

   logic        iss_busy;
   logic [5:0]  iss_k;
   logic [5:0]  iss_col;
   logic        iss_new;

   logic        v1, v2, v3, v4;
   logic [5:0]  k1, k2, k3, k4;
   logic [1:0]  sel1, sel2;
   logic [3:0]  pal3, pal4;
   logic        xm3, xm4, fy0_3, fy0_4;

   logic [15:0] entry;
   logic [2:0]  fy;
   logic [31:0] pat_row;
   logic        last_write;

   logic [7:0]  wr_en;
   logic [8:0]  wr_x   [8];
   logic [7:0]  wr_d   [8];
   logic [2:0]  src_px [8];
   logic [3:0]  col_px [8];
   logic [10:0] xs_px  [8];

   always_comb begin
      state_nx   = state;
      done       = 1'b0;
      last_write = v4 && (k4 == LAST_TILE);
      case (state)
         IDLE:   if (prep) state_nx = FETCH;
         FETCH:  if (!en_r || last_write) state_nx = FINISH;
         FINISH: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Tile RAM is only re-read when the 4-entry group changes; the held address
   // keeps the RAM output stable for the remaining entries of that group.
   always_comb begin
      iss_col = sx_r[8:3] + iss_k;
      iss_new = (iss_k == 6'd0) || (iss_col[5:2] != tilram_addr[3:0]);
      entry   = tilram_rddata[{sel2, 4'b0000} +: 16];
      fy      = ly_r[2:0] ^ {3{entry[15]}};
      pat_row = fy0_4 ? patram_rddata[63:32] : patram_rddata[31:0];
   end

   // Eight pixels of one tile are written per cycle; off-screen pixels
   // (negative x wraps to a large value) are dropped by the single bound check.
   always_comb begin
      for (int unsigned p = 0; p < 8; p++) begin
         src_px[p] = xm4 ? 3'(7 - p) : 3'(p);
         col_px[p] = pat_row[{src_px[p], 2'b00} +: 4];
         xs_px[p]  = {2'b00, k4, 3'b000} + 11'(p) - {8'b0, sx_r[2:0]};
         wr_en[p]  = v4 && en_r && (xs_px[p] < 11'(LINE_W));
         wr_x[p]   = xs_px[p][8:0];
         wr_d[p]   = (col_px[p] == 4'd0) ? '0 : {pal4, col_px[p]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         front       <= 1'b0;
         buf_valid   <= '0;
         ly_r        <= '0;
         sx_r        <= '0;
         en_r        <= 1'b0;
         iss_busy    <= 1'b0;
         iss_k       <= '0;
         tilram_addr <= '0;
         patram_addr <= '0;
         v1          <= 1'b0;
         v2          <= 1'b0;
         v3          <= 1'b0;
         v4          <= 1'b0;
         k1          <= '0;
         k2          <= '0;
         k3          <= '0;
         k4          <= '0;
         sel1        <= '0;
         sel2        <= '0;
         pal3        <= '0;
         pal4        <= '0;
         xm3         <= 1'b0;
         xm4         <= 1'b0;
         fy0_3       <= 1'b0;
         fy0_4       <= 1'b0;
         pixel_data  <= '0;
      end else begin
         state <= state_nx;

         if (state == IDLE && prep) begin
            ly_r     <= 9'(next_row) + scroll[17:9];
            sx_r     <= scroll[8:0];
            en_r     <= enable;
            iss_busy <= enable;
            iss_k    <= '0;
         end

         if (state == FINISH) begin
            front            <= ~front;
            buf_valid[~front] <= en_r;
         end

         v1 <= iss_busy;
         if (iss_busy) begin
            k1   <= iss_k;
            sel1 <= iss_col[1:0];
            if (iss_new) tilram_addr <= {FG, ly_r[8:3], iss_col[5:2]};
            if (iss_k == LAST_TILE) iss_busy <= 1'b0;
            else iss_k <= iss_k + 6'd1;
         end

         v2   <= v1;
         k2   <= k1;
         sel2 <= sel1;

         v3 <= v2;
         if (v2) begin
            patram_addr <= {entry[9:0], fy[2:1]};
            k3          <= k2;
            pal3        <= entry[13:10];
            xm3         <= entry[14];
            fy0_3       <= fy[0];
         end

         v4    <= v3;
         k4    <= k3;
         pal4  <= pal3;
         xm4   <= xm3;
         fy0_4 <= fy0_3;

         pixel_data <= (pixel_addr < 9'(LINE_W) && buf_valid[front]) ?
                       lbuf[front][pixel_addr] : '0;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned p = 0; p < 8; p++) begin
         if (wr_en[p]) lbuf[~front][wr_x[p]] <= wr_d[p];
      end
   end

endmodule

// File: tb/tb_ppu_tile_engine.sv
// Directed bench for ppu_tile_engine with 1-cycle-latency tile and pattern RAM models.
module tb_ppu_tile_engine;

   logic        clk;
   logic        rst_n;
   logic [7:0]  next_row;
   logic [10:0] tilram_addr;
   logic [63:0] tilram_rddata;
   logic [11:0] patram_addr;
   logic [63:0] patram_rddata;
   logic [17:0] scroll;
   logic        enable;
   logic        prep;
   logic [8:0]  pixel_addr;
   logic [7:0]  pixel_data;
   logic        done;

   logic [63:0] tile_ram_tester    [2048];
   logic [63:0] pattern_ram_tester [4096];

   int vectors;
   int miscompares;

   ppu_tile_engine #(.FG(1'b0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .next_row      (next_row),
      .tilram_addr   (tilram_addr),
      .tilram_rddata (tilram_rddata),
      .patram_addr   (patram_addr),
      .patram_rddata (patram_rddata),
      .scroll        (scroll),
      .enable        (enable),
      .prep          (prep),
      .pixel_addr    (pixel_addr),
      .pixel_data    (pixel_data),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      tilram_rddata <= tile_ram_tester[tilram_addr];
      patram_rddata <= pattern_ram_tester[patram_addr];
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_rams();
      for (int i = 0; i < 2048; i++) tile_ram_tester[i] = '0;
      for (int i = 0; i < 4096; i++) pattern_ram_tester[i] = '0;
   endtask

   task automatic read_pix(input logic [8:0] a, output logic [7:0] d);
      pixel_addr = a;
      @(negedge clk);
      d = pixel_data;
   endtask

   // Pulses prep, then watches 200 cycles: counts done pulses, records first-done
   // latency, optionally re-pulses prep at extra_at and reads pixel 222 at mid_at.
   task automatic render(input logic [7:0] row, input logic [17:0] scr, input logic en,
                         input int extra_at, input int mid_at,
                         output int nd, output int lat, output logic [7:0] mid);
      next_row = row;
      scroll   = scr;
      enable   = en;
      prep     = 1'b1;
      @(negedge clk);
      prep = 1'b0;
      nd   = 0;
      lat  = -1;
      mid  = 8'hxx;
      for (int c = 1; c <= 200; c++) begin
         prep = (c == extra_at);
         if (c == mid_at) pixel_addr = 9'd222;
         @(negedge clk);
         if (c == mid_at) mid = pixel_data;
         if (done) begin
            nd++;
            if (lat < 0) lat = c;
         end
      end
      prep = 1'b0;
   endtask

   initial begin
      int          nd, lat, cnt;
      logic [7:0]  d, mid;

      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      next_row    = '0;
      scroll      = '0;
      enable      = 1'b1;
      prep        = 1'b0;
      pixel_addr  = '0;
      clear_rams();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset state
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check_vec("rst_done", 32'(cnt), 0);
      check_vec("rst_tiladdr", 32'(tilram_addr), 0);
      check_vec("rst_pataddr", 32'(patram_addr), 0);
      read_pix(9'd0, d);   check_vec("rst_pix0", 32'(d), 0);
      read_pix(9'd222, d); check_vec("rst_pix222", 32'(d), 0);
      read_pix(9'd319, d); check_vec("rst_pix319", 32'(d), 0);

      // basic tile: col27 pattern 1 palette 3, px6 = 5 -> x 222
      tile_ram_tester[6]    = 64'h0C01_0000_0000_0000;
      pattern_ram_tester[4] = 64'h0000_0000_0500_0000;
      render(8'd0, 18'd0, 1'b1, 0, 0, nd, lat, mid);
      check_vec("basic_done", 32'(nd), 1);
      check_vec("basic_lat", 32'(lat > 0 && lat <= 130), 1);
      read_pix(9'd222, d); check_vec("basic_pix222", 32'(d), 32'h35);
      read_pix(9'd221, d); check_vec("basic_pix221", 32'(d), 0);
      read_pix(9'd223, d); check_vec("basic_pix223", 32'(d), 0);
      read_pix(9'd320, d); check_vec("basic_pix320", 32'(d), 0);

      // x-mirror, second prep while busy, front buffer stable mid-render
      tile_ram_tester[6]    = 64'h4C01_0000_0000_0000;
      pattern_ram_tester[4] = 64'h0000_0000_0500_0090;
      render(8'd0, 18'd0, 1'b1, 5, 10, nd, lat, mid);
      check_vec("busy_done", 32'(nd), 1);
      check_vec("busy_front", 32'(mid), 32'h35);
      read_pix(9'd222, d); check_vec("xmir_pix222", 32'(d), 32'h39);
      read_pix(9'd217, d); check_vec("xmir_pix217", 32'(d), 32'h35);

      // scroll_x = 3
      tile_ram_tester[6] = 64'h0C01_0000_0000_0000;
      render(8'd0, 18'd3, 1'b1, 0, 0, nd, lat, mid);
      check_vec("sx3_done", 32'(nd), 1);
      read_pix(9'd219, d); check_vec("sx3_pix219", 32'(d), 32'h35);
      read_pix(9'd214, d); check_vec("sx3_pix214", 32'(d), 32'h39);
      read_pix(9'd222, d); check_vec("sx3_pix222", 32'(d), 0);

      // scroll_x = 511: col 63 then wrap to col 0
      tile_ram_tester[0]     = 64'h0000_0000_0000_0802;
      tile_ram_tester[15]    = 64'h1003_0000_0000_0000;
      pattern_ram_tester[8]  = 64'h0000_0000_0000_0007;
      pattern_ram_tester[12] = 64'h0000_0000_A000_0000;
      render(8'd0, 18'd511, 1'b1, 0, 0, nd, lat, mid);
      check_vec("sx511_done", 32'(nd), 1);
      check_vec("sx511_lat", 32'(lat > 0 && lat <= 130), 1);
      read_pix(9'd0, d);   check_vec("sx511_pix0", 32'(d), 32'h4A);
      check_vec("sx511_nox", 32'($isunknown(pixel_data)), 0);
      read_pix(9'd1, d);   check_vec("sx511_pix1", 32'(d), 32'h27);
      read_pix(9'd223, d); check_vec("sx511_pix223", 32'(d), 32'h35);
      read_pix(9'd218, d); check_vec("sx511_pix218", 32'(d), 32'h39);

      // scroll_y = 8 -> tile row 1, with y-mirror on tile (row1,col5)
      tile_ram_tester[17]    = 64'h0000_0000_9804_0000;
      pattern_ram_tester[19] = 64'h0000_000C_0000_0000;
      render(8'd0, 18'd4096, 1'b1, 0, 0, nd, lat, mid);
      check_vec("sy8_done", 32'(nd), 1);
      check_vec("sy8_tiladdr", 32'(tilram_addr), 32'h01A);
      read_pix(9'd40, d);  check_vec("sy8_pix40", 32'(d), 32'h6C);
      read_pix(9'd222, d); check_vec("sy8_pix222", 32'(d), 0);

      // layer disabled
      render(8'd0, 18'd4096, 1'b0, 0, 0, nd, lat, mid);
      check_vec("dis_done", 32'(nd), 1);
      check_vec("dis_lat", 32'(lat > 0 && lat <= 130), 1);
      read_pix(9'd40, d);  check_vec("dis_pix40", 32'(d), 0);
      read_pix(9'd0, d);   check_vec("dis_pix0", 32'(d), 0);

      // reset mid-render
      render(8'd0, 18'd0, 1'b1, 0, 0, nd, lat, mid);
      read_pix(9'd222, d); check_vec("pre_rst_pix222", 32'(d), 32'h35);
      enable = 1'b1;
      scroll = 18'd0;
      prep   = 1'b1;
      @(negedge clk);
      prep = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 150; c++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check_vec("midrst_done", 32'(cnt), 0);
      read_pix(9'd222, d); check_vec("midrst_pix222", 32'(d), 0);
      read_pix(9'd40, d);  check_vec("midrst_pix40", 32'(d), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
